fp_add_arbiter: RTL and testbench

Round-robin arbiter that time-shares one combinational `fp_add` fixed-point adder among `N_REQ` requesters. Each requester has a valid/ready operand channel. Results return on one shared response channel tagged with the requester index. The block instantiates `fp_add` internally, registers its operands and results, and keeps a saturating count of overflow/underflow events. It sits between the datapath clients and the adder, so no client drives `fp_add` directly.

---
 rtl/fp_add_arbiter_if.sv | 38 +++
 rtl/fp_add_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_arbiter_if.sv
// Requester/response bundle between datapath clients and fp_add_arbiter.
// The master side belongs to the clients; the slave side belongs to the arbiter.
interface fp_add_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W1    = 16,
  parameter int W2    = 16,
  parameter int W3    = 16,
  parameter int CNT_W = 8,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*W1-1:0] req_in1;
  logic [N_REQ-1:0]    req_sign1;
  logic [N_REQ*W2-1:0] req_in2;
  logic [N_REQ-1:0]    req_sign2;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [W3-1:0]       rsp_out;
  logic                rsp_sign;
  logic                rsp_overflow;
  logic                rsp_underflow;
  logic [CNT_W-1:0]    err_cnt;
  logic                busy;

  modport master (
    output req_valid, req_in1, req_sign1, req_in2, req_sign2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_sign, rsp_overflow,
           rsp_underflow, err_cnt, busy
  );

  modport slave (
    input  req_valid, req_in1, req_sign1, req_in2, req_sign2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_sign, rsp_overflow,
           rsp_underflow, err_cnt, busy
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter time-sharing one combinational fixed-point adder (fp_add)
// among N_REQ requesters, with registered operands/results and a saturating error count.

// Fixed-point adder: operands aligned to the finest fraction, result truncated
// toward -inf and saturated to the result format. A result is two's complement
// whenever either operand is signed; otherwise it is unsigned.
module fp_add #(
  parameter int i1 = 2,
  parameter int f1 = 14,
  parameter int i2 = 2,
  parameter int f2 = 14,
  parameter int i3 = 2,
  parameter int f3 = 14
) (
  input  logic [i1+f1-1:0] in1,
  input  logic             sign1,
  input  logic [i2+f2-1:0] in2,
  input  logic             sign2,
  output logic [i3+f3-1:0] out,
  output logic             o_sign,
  output logic             overflow,
  output logic             underflow
);
  localparam int W1  = i1 + f1;
  localparam int W2  = i2 + f2;
  localparam int W3  = i3 + f3;
  localparam int FW  = (f1 > f2) ? ((f1 > f3) ? f1 : f3) : ((f2 > f3) ? f2 : f3);
  localparam int IM  = (i1 > i2) ? ((i1 > i3) ? i1 : i3) : ((i2 > i3) ? i2 : i3);
  localparam int W   = IM + 2 + FW;
  localparam int SH1 = FW - f1;
  localparam int SH2 = FW - f2;
  localparam int SH3 = FW - f3;

  localparam logic signed [W-1:0] MAX_U = {{(W-W3){1'b0}}, {W3{1'b1}}};
  localparam logic signed [W-1:0] MAX_S = {{(W-W3+1){1'b0}}, {(W3-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_S = {{(W-W3+1){1'b1}}, {(W3-1){1'b0}}};

  logic signed [W-1:0] a_ext, b_ext, sum, scaled, hi, lo;

  always_comb begin
    a_ext     = {{(W-W1){sign1 & in1[W1-1]}}, in1} <<< SH1;
    b_ext     = {{(W-W2){sign2 & in2[W2-1]}}, in2} <<< SH2;
    sum       = a_ext + b_ext;
    scaled    = sum >>> SH3;
    hi        = (sign1 | sign2) ? MAX_S : MAX_U;
    lo        = (sign1 | sign2) ? MIN_S : '0;
    overflow  = scaled > hi;
    underflow = scaled < lo;
    o_sign    = sum[W-1];
    if (overflow)       out = hi[W3-1:0];
    else if (underflow) out = lo[W3-1:0];
    else                out = scaled[W3-1:0];
  end
endmodule

// state | meaning
// IDLE  | arbitrate; grant one valid requester and latch its operands
// CALC  | adder fed from operand registers; results registered on exit
// RESP  | rsp_valid high, results held until rsp_ready
module fp_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int i1    = 2,
  parameter int f1    = 14,
  parameter int i2    = 2,
  parameter int f2    = 14,
  parameter int i3    = 2,
  parameter int f3    = 14,
  parameter int CNT_W = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic              clk,
  input logic              rst_n,
  fp_add_arbiter_if.slave  bus
);
  localparam int W1 = i1 + f1;
  localparam int W2 = i2 + f2;
  localparam int W3 = i3 + f3;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, id_q, rsp_id_q;
  logic [W1-1:0]    in1_q;
  logic [W2-1:0]    in2_q;
  logic             sign1_q, sign2_q;
  logic [W3-1:0]    rsp_out_q;
  logic             rsp_sign_q, rsp_ovf_q, rsp_unf_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic [W3-1:0]    add_out;
  logic             add_sign, add_ovf, add_unf;

  fp_add #(
    .i1(i1), .f1(f1), .i2(i2), .f2(f2), .i3(i3), .f3(f3)
  ) u_fp_add (
    .in1      (in1_q),
    .sign1    (sign1_q),
    .in2      (in2_q),
    .sign2    (sign2_q),
    .out      (add_out),
    .o_sign   (add_sign),
    .overflow (add_ovf),
    .underflow(add_unf)
  );

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    int j;
    logic [ID_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    j         = 0;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = ID_W'(j);
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst_n gates req_ready so no grant is advertised while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state_q == IDLE && grant_vld) bus.req_ready[grant_idx] = 1'b1;
    bus.rsp_valid = (state_q == RESP);
    bus.busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= ID_W'(N_REQ - 1);
      id_q       <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      rsp_id_q   <= '0;
      rsp_out_q  <= '0;
      rsp_sign_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_unf_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (state_q == IDLE && grant_vld) begin
        ptr_q   <= grant_idx;
        id_q    <= grant_idx;
        in1_q   <= bus.req_in1[int'(grant_idx)*W1 +: W1];
        in2_q   <= bus.req_in2[int'(grant_idx)*W2 +: W2];
        sign1_q <= bus.req_sign1[grant_idx];
        sign2_q <= bus.req_sign2[grant_idx];
      end
      if (state_q == CALC) begin
        rsp_id_q   <= id_q;
        rsp_out_q  <= add_out;
        rsp_sign_q <= add_sign;
        rsp_ovf_q  <= add_ovf;
        rsp_unf_q  <= add_unf;
      end
      if (state_q == RESP && bus.rsp_ready && (rsp_ovf_q || rsp_unf_q) && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + CNT_ONE;
    end
  end

  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_out       = rsp_out_q;
  assign bus.rsp_sign      = rsp_sign_q;
  assign bus.rsp_overflow  = rsp_ovf_q;
  assign bus.rsp_underflow = rsp_unf_q;
  assign bus.err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: reset, arithmetic, round-robin order,
// backpressure, mid-flight reset and error-counter saturation (second instance, CNT_W=2).
module tb_fp_add_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  fp_add_arbiter_if #(.N_REQ(4), .W1(16), .W2(16), .W3(16), .CNT_W(8)) bus ();
  fp_add_arbiter_if #(.N_REQ(4), .W1(16), .W2(16), .W3(16), .CNT_W(2)) bus_s ();

  fp_add_arbiter #(.N_REQ(4), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  fp_add_arbiter #(.N_REQ(4), .CNT_W(2)) dut_sat (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int k, input logic [15:0] a, input logic sa,
                           input logic [15:0] b, input logic sb);
    bus.req_valid[k]         = 1'b1;
    bus.req_in1[k*16 +: 16]  = a;
    bus.req_sign1[k]         = sa;
    bus.req_in2[k*16 +: 16]  = b;
    bus.req_sign2[k]         = sb;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    #12;
    n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if (bus.err_cnt !== 8'd0) $display("FAIL reset_err_cnt got %0d exp 0", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.rsp_out !== 16'h0000) $display("FAIL reset_rsp_out got %h exp 0000", bus.rsp_out); else n_pass++;
    n_checks++; if (bus.rsp_id !== 2'd0) $display("FAIL reset_rsp_id got %0d exp 0", bus.rsp_id); else n_pass++;
    n_checks++; if ({bus.rsp_sign, bus.rsp_overflow, bus.rsp_underflow} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {bus.rsp_sign, bus.rsp_overflow, bus.rsp_underflow}); else n_pass++;
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_add;
    bus.rsp_ready = 1'b1;
    drive_req(0, 16'h4000, 1'b0, 16'h2000, 1'b0);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL uadd_grant got %b exp 0001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    n_checks++; if ({bus.rsp_valid, bus.busy} !== 2'b01) $display("FAIL uadd_calc got valid,busy=%b exp 01", {bus.rsp_valid, bus.busy}); else n_pass++;
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL uadd_rsp_valid got %b exp 1", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_id !== 2'd0) $display("FAIL uadd_rsp_id got %0d exp 0", bus.rsp_id); else n_pass++;
    n_checks++; if (bus.rsp_out !== 16'h6000) $display("FAIL uadd_rsp_out got %h exp 6000", bus.rsp_out); else n_pass++;
    n_checks++; if (bus.rsp_overflow !== 1'b0) $display("FAIL uadd_overflow got %b exp 0", bus.rsp_overflow); else n_pass++;
    tick();
    n_checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) $display("FAIL uadd_idle got valid,busy=%b exp 00", {bus.rsp_valid, bus.busy}); else n_pass++;
  endtask

  task automatic test_signed_add;
    bus.rsp_ready = 1'b1;
    drive_req(2, 16'hC000, 1'b1, 16'h2000, 1'b1);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) $display("FAIL sadd_grant got %b exp 0100", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    tick();
    n_checks++; if (bus.rsp_id !== 2'd2) $display("FAIL sadd_rsp_id got %0d exp 2", bus.rsp_id); else n_pass++;
    n_checks++; if (bus.rsp_out !== 16'hE000) $display("FAIL sadd_rsp_out got %h exp e000", bus.rsp_out); else n_pass++;
    n_checks++; if ({bus.rsp_sign, bus.rsp_overflow, bus.rsp_underflow} !== 3'b100)
      $display("FAIL sadd_flags got %b exp 100", {bus.rsp_sign, bus.rsp_overflow, bus.rsp_underflow}); else n_pass++;
    tick();
  endtask

  task automatic test_overflow;
    bus.rsp_ready = 1'b0;
    drive_req(1, 16'hC000, 1'b0, 16'h6000, 1'b0);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) $display("FAIL ovf_grant got %b exp 0010", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    tick();
    n_checks++; if (bus.rsp_overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", bus.rsp_overflow); else n_pass++;
    n_checks++; if (bus.rsp_out !== 16'hFFFF) $display("FAIL ovf_sat_out got %h exp ffff", bus.rsp_out); else n_pass++;
    n_checks++; if (bus.err_cnt !== 8'd0) $display("FAIL ovf_cnt_before got %0d exp 0", bus.err_cnt); else n_pass++;
    bus.rsp_ready = 1'b1;
    tick();
    n_checks++; if (bus.err_cnt !== 8'd1) $display("FAIL ovf_cnt_after got %0d exp 1", bus.err_cnt); else n_pass++;
  endtask

  task automatic test_round_robin;
    int grants[$];
    int cycles[$];
    int multi;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) drive_req(k, 16'(k * 16'h0100), 1'b0, 16'h0010, 1'b0);
    #1;
    multi = 0;
    for (int c = 0; c < 24; c++) begin
      if ($countones(bus.req_ready) > 1) multi++;
      for (int k = 0; k < 4; k++) begin
        if (bus.req_ready[k]) begin
          grants.push_back(k);
          cycles.push_back(c);
        end
      end
      tick();
    end
    bus.req_valid = '0;
    n_checks++; if (multi !== 0) $display("FAIL rr_onehot got %0d multi-grant cycles exp 0", multi); else n_pass++;
    n_checks++; if (grants.size() !== 8) $display("FAIL rr_count got %0d exp 8", grants.size()); else n_pass++;
    for (int g = 0; g < grants.size() && g < 8; g++) begin
      n_checks++; if (grants[g] !== g % 4) $display("FAIL rr_order[%0d] got %0d exp %0d", g, grants[g], g % 4); else n_pass++;
      if (g > 0) begin
        n_checks++; if (cycles[g] - cycles[g-1] !== 3) $display("FAIL rr_gap[%0d] got %0d exp 3", g, cycles[g] - cycles[g-1]); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure;
    bus.rsp_ready = 1'b0;
    drive_req(3, 16'h1000, 1'b0, 16'h1000, 1'b0);
    #1;
    n_checks++; if (bus.req_ready !== 4'b1000) $display("FAIL bp_grant got %b exp 1000", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    drive_req(0, 16'h0800, 1'b0, 16'h0800, 1'b0);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL bp_calc_ready got %b exp 0000", bus.req_ready); else n_pass++;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %b exp 1", c, bus.rsp_valid); else n_pass++;
      n_checks++; if (bus.rsp_out !== 16'h2000) $display("FAIL bp_hold_out[%0d] got %h exp 2000", c, bus.rsp_out); else n_pass++;
      n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL bp_hold_ready[%0d] got %b exp 0000", c, bus.req_ready); else n_pass++;
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++; if ({bus.rsp_valid, bus.rsp_id} !== 3'b111) $display("FAIL bp_release got valid,id=%b exp 111", {bus.rsp_valid, bus.rsp_id}); else n_pass++;
    tick();
    n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL bp_next_grant got %b exp 0001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    tick();
    n_checks++; if ({bus.rsp_id, bus.rsp_out} !== {2'd0, 16'h1000}) $display("FAIL bp_next_rsp got id=%0d out=%h exp id=0 out=1000", bus.rsp_id, bus.rsp_out); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid;
    bus.rsp_ready = 1'b1;
    drive_req(2, 16'h0100, 1'b0, 16'h0100, 1'b0);
    tick();
    bus.req_valid = '0;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL rmid_calc_busy got %b exp 1", bus.busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) $display("FAIL rmid_calc_reset got valid,busy=%b exp 00", {bus.rsp_valid, bus.busy}); else n_pass++;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) drive_req(k, 16'h0040, 1'b0, 16'h0040, 1'b0);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL rmid_regrant got %b exp 0001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    tick();
    n_checks++; if ({bus.rsp_id, bus.rsp_out} !== {2'd0, 16'h0080}) $display("FAIL rmid_rsp got id=%0d out=%h exp id=0 out=0080", bus.rsp_id, bus.rsp_out); else n_pass++;
    tick();
    bus.rsp_ready = 1'b0;
    drive_req(1, 16'h0200, 1'b0, 16'h0200, 1'b0);
    tick();
    bus.req_valid = '0;
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL rmid_resp_valid got %b exp 1", bus.rsp_valid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.rsp_valid, bus.busy, bus.rsp_out} !== {2'b00, 16'h0000})
      $display("FAIL rmid_resp_reset got valid=%b busy=%b out=%h exp 0 0 0000", bus.rsp_valid, bus.busy, bus.rsp_out); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_err_saturation;
    bus_s.rsp_ready = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      bus_s.req_valid[0]  = 1'b1;
      bus_s.req_in1[15:0] = 16'hC000;
      bus_s.req_in2[15:0] = 16'h6000;
      #1;
      n_checks++; if (bus_s.req_ready !== 4'b0001) $display("FAIL sat_grant[%0d] got %b exp 0001", n, bus_s.req_ready); else n_pass++;
      tick();
      bus_s.req_valid = '0;
      tick();
      tick();
      n_checks++;
      if (bus_s.err_cnt !== 2'((n > 3) ? 3 : n)) $display("FAIL sat_cnt[%0d] got %0d exp %0d", n, bus_s.err_cnt, (n > 3) ? 3 : n);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks        = 0;
    n_pass          = 0;
    rst_n           = 1'b0;
    bus.req_valid   = '0;
    bus.req_in1     = '0;
    bus.req_sign1   = '0;
    bus.req_in2     = '0;
    bus.req_sign2   = '0;
    bus.rsp_ready   = 1'b0;
    bus_s.req_valid = '0;
    bus_s.req_in1   = '0;
    bus_s.req_sign1 = '0;
    bus_s.req_in2   = '0;
    bus_s.req_sign2 = '0;
    bus_s.rsp_ready = 1'b0;
    test_reset();
    test_unsigned_add();
    test_signed_add();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_err_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout: %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
